// File: rtl/serial_pkg.sv
// Shared definitions for the bit-serial link cells: FSM state encoding and
// the counter-width helper.
package serial_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/And.sv
// Gate library: 2-input AND.
module And (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = a & b;
endmodule

// File: rtl/And_not.sv
// Gate library: a AND NOT b.
module And_not (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = a & ~b;
endmodule

// File: rtl/Not.sv
// Gate library: inverter.
module Not (
  input  logic a,
  output logic y
);
  assign y = ~a;
endmodule

// File: rtl/Or.sv
// Gate library: 2-input OR.
module Or (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = a | b;
endmodule

// File: rtl/or_4bit.sv
// Gate library: 4-input OR reduction.
module or_4bit (
  input  logic [3:0] a,
  output logic       y
);
  assign y = |a;
endmodule

// File: rtl/reg_cell.sv
// 1-bit storage cell: D flip-flop with synchronous active-high reset and
// load enable (hold when en is low).
module reg_cell (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic d,
  output logic q
);
  logic q_q;
  logic q_d;

  always_comb q_d = en ? d : q_q;

  always_ff @(posedge clk) begin
    if (rst) q_q <= 1'b0;
    else     q_q <= q_d;
  end

  assign q = q_q;
endmodule

// File: rtl/bit_serial_tx.sv
// Parallel-to-serial transmitter: accepts a WIDTH-bit word on valid/ready and
// shifts it out LSB-first with a per-bit strobe and a one-cycle done pulse.
module bit_serial_tx
  import serial_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] din,
  output logic             sout,
  output logic             sout_valid,
  output logic             done,
  output logic             busy
);
  localparam int NG = (CNT_W + 3) / 4;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, inc, carry, x1, x2;
  logic [WIDTH-1:0] shreg_q, shreg_d, shifted, ld_bit, sh_bit;
  logic [4*NG-1:0]  mis;
  logic [NG-1:0]    grp, any_chain;
  logic any_st, is_idle, is_shift, is_done, accept, adv_en;
  logic cnt_last, stay_shift;

  // Encoding: bit0 alone marks ST_SHIFT, bit1 alone marks ST_DONE.
  Or      u_any   (.a(state_q[0]), .b(state_q[1]), .y(any_st));
  Not     u_idle  (.a(any_st), .y(is_idle));
  And_not u_shift (.a(state_q[0]), .b(state_q[1]), .y(is_shift));
  And_not u_done  (.a(state_q[1]), .b(state_q[0]), .y(is_done));
  And     u_acc   (.a(in_valid), .b(is_idle), .y(accept));
  Or      u_adv   (.a(accept), .b(is_shift), .y(adv_en));

  // Counter end detect: a bit mismatches LAST when it differs from the constant.
  for (genvar i = 0; i < CNT_W; i++) begin : g_mis
    if (LAST[i]) begin : g_inv
      Not u_n (.a(cnt_q[i]), .y(mis[i]));
    end else begin : g_pass
      assign mis[i] = cnt_q[i];
    end
  end
  if (4 * NG > CNT_W) begin : g_pad
    assign mis[4*NG-1:CNT_W] = '0;
  end
  for (genvar g = 0; g < NG; g++) begin : g_grp
    or_4bit u_or4 (.a(mis[4*g +: 4]), .y(grp[g]));
    if (g == 0) begin : g_first
      assign any_chain[0] = grp[0];
    end else begin : g_chain
      Or u_ch (.a(any_chain[g-1]), .b(grp[g]), .y(any_chain[g]));
    end
  end
  Not u_eq (.a(any_chain[NG-1]), .y(cnt_last));

  And     u_last (.a(is_shift), .b(cnt_last), .y(state_d[1]));
  And_not u_stay (.a(is_shift), .b(cnt_last), .y(stay_shift));
  Or      u_s0   (.a(accept), .b(stay_shift), .y(state_d[0]));

  for (genvar i = 0; i < 2; i++) begin : g_state
    reg_cell u_st (.clk(clk), .rst(rst), .en(1'b1), .d(state_d[i]), .q(state_q[i]));
  end

  // Ripple incrementer built from XOR = (a&~b)|(b&~a); accept clears it.
  assign carry[0] = 1'b1;
  for (genvar i = 0; i < CNT_W; i++) begin : g_cnt
    And_not u_x1  (.a(cnt_q[i]), .b(carry[i]), .y(x1[i]));
    And_not u_x2  (.a(carry[i]), .b(cnt_q[i]), .y(x2[i]));
    Or      u_xo  (.a(x1[i]), .b(x2[i]), .y(inc[i]));
    And_not u_clr (.a(inc[i]), .b(accept), .y(cnt_d[i]));
    if (i < CNT_W - 1) begin : g_cy
      And u_cy (.a(cnt_q[i]), .b(carry[i]), .y(carry[i+1]));
    end
    reg_cell u_cr (.clk(clk), .rst(rst), .en(adv_en), .d(cnt_d[i]), .q(cnt_q[i]));
  end

  assign shifted = {1'b0, shreg_q[WIDTH-1:1]};
  for (genvar i = 0; i < WIDTH; i++) begin : g_sh
    And     u_ld (.a(accept), .b(din[i]), .y(ld_bit[i]));
    And_not u_sh (.a(shifted[i]), .b(accept), .y(sh_bit[i]));
    Or      u_mx (.a(ld_bit[i]), .b(sh_bit[i]), .y(shreg_d[i]));
    reg_cell u_sr (.clk(clk), .rst(rst), .en(adv_en), .d(shreg_d[i]), .q(shreg_q[i]));
  end

  And u_sout (.a(shreg_q[0]), .b(is_shift), .y(sout));
  assign in_ready   = is_idle;
  assign sout_valid = is_shift;
  assign done       = is_done;
  assign busy       = any_st;
endmodule
